// File: rtl/sprite_draw_pkg.sv
// Shared encodings for the sprite draw engine: command modes, FSM states,
// screen geometry and the transparent colour key.
package sprite_draw_pkg;

    localparam logic [1:0] MODE_DRAW  = 2'b00;
    localparam logic [1:0] MODE_ERASE = 2'b01;
    localparam logic [1:0] MODE_CLEAR = 2'b10;
    localparam logic [1:0] MODE_RSVD  = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SCAN,
        ST_FLUSH,
        ST_DONE
    } state_e;

    localparam int SCREEN_W = 320;
    localparam int SCREEN_H = 240;

    // All-ones key; sliced down to the colour width where it is compared.
    localparam logic [31:0] TRANSP_KEY = '1;

endpackage

// File: rtl/sprite_scan_counter.sv
// Row-major 2-D scan counter: cx runs 0..cx_max_i (inner), cy 0..cy_max_i
// (outer). last_o flags the final coordinate of the rectangle.
module sprite_scan_counter #(
    parameter int CX_W = 9,
    parameter int CY_W = 8
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            clr_i,
    input  logic            en_i,
    input  logic [CX_W-1:0] cx_max_i,
    input  logic [CY_W-1:0] cy_max_i,
    output logic [CX_W-1:0] cx_o,
    output logic [CY_W-1:0] cy_o,
    output logic            last_o
);

    logic [CX_W-1:0] cx_q, cx_d;
    logic [CY_W-1:0] cy_q, cy_d;

    // Next coordinate: clear wins, otherwise step and wrap at the limits.
    always_comb begin
        cx_d = cx_q;
        cy_d = cy_q;
        if (clr_i) begin
            cx_d = '0;
            cy_d = '0;
        end else if (en_i) begin
            if (cx_q == cx_max_i) begin
                cx_d = '0;
                cy_d = (cy_q == cy_max_i) ? '0 : cy_q + 1'b1;
            end else begin
                cx_d = cx_q + 1'b1;
            end
        end
    end

    // Coordinate registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cx_q <= '0;
            cy_q <= '0;
        end else begin
            cx_q <= cx_d;
            cy_q <= cy_d;
        end
    end

    assign cx_o   = cx_q;
    assign cy_o   = cy_q;
    assign last_o = (cx_q == cx_max_i) && (cy_q == cy_max_i);

endmodule

// File: rtl/sprite_draw_engine.sv
// Sprite draw / erase / clear engine feeding a VGA pixel-write port.
// One pixel per cycle; pixel outputs trail the ROM address by one cycle to
// match the synchronous sprite ROM. Build option SPRITE_TRANSPARENCY_EN
// suppresses plotting of all-ones draw pixels.
module sprite_draw_engine
    import sprite_draw_pkg::*;
#(
    parameter int N_SPR    = 4,
    parameter int SPR_W    = 16,
    parameter int SPR_H    = 16,
    parameter int COLOUR_W = 15,
    parameter logic [COLOUR_W-1:0] BG_COLOUR = '0,
    localparam int IDW = $clog2(N_SPR),
    localparam int AW  = $clog2(N_SPR*SPR_W*SPR_H)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic [1:0]          mode,
    input  logic [IDW-1:0]      spr_id,
    input  logic [8:0]          loc_x,
    input  logic [7:0]          loc_y,
    output logic [AW-1:0]       rom_addr,
    input  logic [COLOUR_W-1:0] rom_data,
    output logic [8:0]          X,
    output logic [7:0]          Y,
    output logic [COLOUR_W-1:0] colour,
    output logic                plot,
    output logic                busy,
    output logic                done
);

    state_e         state_q, state_d;
    logic [1:0]     mode_q, mode_d;
    logic [IDW-1:0] spr_q, spr_d;
    logic [8:0]     lx_q, lx_d;
    logic [7:0]     ly_q, ly_d;
    logic           pv_q, pv_d;
    logic [9:0]     px_q, px_d;
    logic [8:0]     py_q, py_d;

    logic       accept;
    logic       last;
    logic [8:0] cx, cx_max;
    logic [7:0] cy, cy_max;
    logic       in_screen, is_draw, transp;

    assign cx_max = (mode_q == MODE_CLEAR) ? 9'(SCREEN_W-1) : 9'(SPR_W-1);
    assign cy_max = (mode_q == MODE_CLEAR) ? 8'(SCREEN_H-1) : 8'(SPR_H-1);

    sprite_scan_counter #(.CX_W(9), .CY_W(8)) u_scan (
        .clk      (clk),
        .reset    (reset),
        .clr_i    (accept),
        .en_i     (state_q == ST_SCAN),
        .cx_max_i (cx_max),
        .cy_max_i (cy_max),
        .cx_o     (cx),
        .cy_o     (cy),
        .last_o   (last)
    );

    // Command FSM: accept in IDLE only, scan, flush the pipelined pixel, pulse done.
    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        spr_d   = spr_q;
        lx_d    = lx_q;
        ly_d    = ly_q;
        accept  = 1'b0;
        busy    = 1'b0;
        done    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start && mode != MODE_RSVD) begin
                    accept  = 1'b1;
                    state_d = ST_SCAN;
                    mode_d  = mode;
                    spr_d   = spr_id;
                    lx_d    = (mode == MODE_CLEAR) ? 9'd0 : loc_x;
                    ly_d    = (mode == MODE_CLEAR) ? 8'd0 : loc_y;
                end
            end
            ST_SCAN: begin
                busy = 1'b1;
                if (last) state_d = ST_FLUSH;
            end
            ST_FLUSH: begin
                busy    = 1'b1;
                state_d = ST_DONE;
            end
            ST_DONE: begin
                done    = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Pixel stage: screen coordinates one bit wider so off-screen sums never wrap.
    always_comb begin
        pv_d = (state_q == ST_SCAN);
        px_d = pv_d ? ({1'b0, lx_q} + {1'b0, cx}) : px_q;
        py_d = pv_d ? ({1'b0, ly_q} + {1'b0, cy}) : py_q;
    end

    // State, latched command and pixel-stage registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            mode_q  <= MODE_DRAW;
            spr_q   <= '0;
            lx_q    <= '0;
            ly_q    <= '0;
            pv_q    <= 1'b0;
            px_q    <= '0;
            py_q    <= '0;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            spr_q   <= spr_d;
            lx_q    <= lx_d;
            ly_q    <= ly_d;
            pv_q    <= pv_d;
            px_q    <= px_d;
            py_q    <= py_d;
        end
    end

    assign rom_addr = AW'(spr_q) * AW'(SPR_W*SPR_H) + AW'(cy) * AW'(SPR_W) + AW'(cx);

    assign is_draw   = (mode_q == MODE_DRAW);
    assign in_screen = (px_q < 10'(SCREEN_W)) && (py_q < 9'(SCREEN_H));

`ifdef SPRITE_TRANSPARENCY_EN
    assign transp = is_draw && (rom_data == TRANSP_KEY[COLOUR_W-1:0]);
`else
    assign transp = 1'b0;
`endif

    assign plot   = pv_q && in_screen && !transp;
    assign colour = !pv_q ? '0 : (is_draw ? rom_data : BG_COLOUR);
    assign X      = px_q[8:0];
    assign Y      = py_q[7:0];

endmodule

// File: tb/tb_sprite_draw_engine.sv
// Directed bench for sprite_draw_engine with a behavioural sprite ROM.
module tb_sprite_draw_engine;

`ifdef SPRITE_TRANSPARENCY_EN
    localparam bit TRANSP = 1'b1;
`else
    localparam bit TRANSP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset, start;
    logic [1:0]  mode, spr_id;
    logic [8:0]  loc_x;
    logic [7:0]  loc_y;
    logic [9:0]  rom_addr;
    logic [14:0] rom_data;
    logic [8:0]  X;
    logic [7:0]  Y;
    logic [14:0] colour;
    logic        plot, busy, done;

    int checks = 0;
    int errors = 0;
    int last_done_win = -1;

    always #5 clk = ~clk;

    sprite_draw_engine dut (
        .clk(clk), .reset(reset), .start(start), .mode(mode), .spr_id(spr_id),
        .loc_x(loc_x), .loc_y(loc_y), .rom_addr(rom_addr), .rom_data(rom_data),
        .X(X), .Y(Y), .colour(colour), .plot(plot), .busy(busy), .done(done)
    );

    // Sprite 1 row 3 (addresses 304..319) holds the transparent key.
    function automatic logic [14:0] rom_val(input int a);
        if (a >= 304 && a < 320) return 15'h7FFF;
        return 15'(a * 7 + 3);
    endfunction

    always @(posedge clk) rom_data <= rom_val(int'(rom_addr));

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d required %0d", tag, obs, exp);
        end
    endtask

    // Called at a falling edge; returns in the first cycle after acceptance,
    // with the command inputs scrambled to prove they were latched.
    task automatic pulse_start(input logic [1:0] m, input int id, input int lx, input int ly);
        start = 1'b1; mode = m; spr_id = 2'(id); loc_x = 9'(lx); loc_y = 8'(ly);
        @(negedge clk);
        start = 1'b0; mode = ~m; spr_id = ~spr_id; loc_x = ~loc_x; loc_y = ~loc_y;
    endtask

    task automatic run_op(input string tag, input logic [1:0] m, input int id,
                          input int lx, input int ly, input int exp_plots,
                          input int exp_busy, input bit inj_busy, input bit inj_done);
        int W, H, N, p, ex, ey;
        int bad_addr, bad_pix, bad_busy, bad_done, plots, dones, busy_cnt, done_win;
        bit ep, draw;
        logic [14:0] ec;
        bad_addr = 0; bad_pix = 0; bad_busy = 0; bad_done = 0;
        plots = 0; dones = 0; busy_cnt = 0; done_win = -1;
        draw = (m == 2'b00);
        pulse_start(m, id, lx, ly);
        if (m == 2'b10) begin W = 320; H = 240; lx = 0; ly = 0; end
        else begin W = 16; H = 16; end
        N = W * H;
        for (int n = 0; n <= N + 3; n++) begin
            if (busy !== (n <= N)) bad_busy++;
            if (busy === 1'b1) busy_cnt++;
            if (done !== (n == N + 1)) bad_done++;
            if (done === 1'b1) begin dones++; done_win = n; end
            if (draw && n < N && rom_addr !== 10'(id * 256 + n)) bad_addr++;
            ep = 1'b0; ec = '0; ex = 0; ey = 0;
            if (n >= 1 && n <= N) begin
                p  = n - 1;
                ex = lx + p % W;
                ey = ly + p / W;
                ep = (ex < 320) && (ey < 240);
                ec = draw ? rom_val(id * 256 + p) : 15'h0;
                if (TRANSP && draw && ec == 15'h7FFF) ep = 1'b0;
            end
            if (plot !== ep) bad_pix++;
            else if (ep && (X !== 9'(ex) || Y !== 8'(ey) || colour !== ec)) bad_pix++;
            if (plot === 1'b1) plots++;
            if (inj_busy && n == 50) begin
                start = 1'b1; mode = 2'b10; spr_id = 2'd3; loc_x = 9'd0; loc_y = 8'd0;
            end else if (inj_done && n == N + 1) begin
                start = 1'b1; mode = 2'b00; spr_id = 2'd0; loc_x = 9'd1; loc_y = 8'd1;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
        end
        start = 1'b0;
        check({tag, "_rom_addr_bad"}, bad_addr, 0);
        check({tag, "_pixel_bad"}, bad_pix, 0);
        check({tag, "_busy_bad"}, bad_busy, 0);
        check({tag, "_done_bad"}, bad_done, 0);
        check({tag, "_plot_count"}, plots, exp_plots);
        check({tag, "_busy_cycles"}, busy_cnt, exp_busy);
        check({tag, "_done_pulses"}, dones, 1);
        last_done_win = done_win;
    endtask

    initial begin
        int bad;
        reset = 1'b0; start = 1'b0; mode = 2'b00; spr_id = 2'd0; loc_x = 9'd0; loc_y = 8'd0;
        repeat (2) @(negedge clk);
        check("rst_rom_addr", rom_addr, 0);
        check("rst_X", X, 0);
        check("rst_Y", Y, 0);
        check("rst_colour", colour, 0);
        check("rst_plot", plot, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        reset = 1'b1;
        @(negedge clk);

        // Reserved mode is ignored entirely.
        pulse_start(2'b11, 1, 5, 5);
        bad = 0;
        for (int n = 0; n < 4; n++) begin
            if (busy !== 1'b0 || done !== 1'b0 || plot !== 1'b0) bad++;
            @(negedge clk);
        end
        check("rsvd_mode_activity", bad, 0);

        // Draw sprite 2 at (10,20), with stray starts mid-scan and in DONE.
        run_op("draw", 2'b00, 2, 10, 20, 256, 257, 1'b1, 1'b1);
        check("draw_done_cycle", last_done_win + 1, 258);

        run_op("clip", 2'b00, 0, 310, 230, 100, 257, 1'b0, 1'b0);
        run_op("erase", 2'b01, 1, 100, 100, 256, 257, 1'b0, 1'b0);
        run_op("transp", 2'b00, 1, 50, 60, TRANSP ? 240 : 256, 257, 1'b0, 1'b0);

        // Reset in the middle of a draw.
        pulse_start(2'b00, 2, 40, 40);
        repeat (100) @(negedge clk);
        check("rstmid_pre_plot", plot, 1);
        #1 reset = 1'b0;
        #1;
        check("rstmid_rom_addr", rom_addr, 0);
        check("rstmid_X", X, 0);
        check("rstmid_Y", Y, 0);
        check("rstmid_colour", colour, 0);
        check("rstmid_plot", plot, 0);
        check("rstmid_busy", busy, 0);
        check("rstmid_done", done, 0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        bad = 0;
        for (int n = 0; n < 300; n++) begin
            if (busy !== 1'b0 || done !== 1'b0 || plot !== 1'b0) bad++;
            @(negedge clk);
        end
        check("rstmid_after_release", bad, 0);

        // Clear screen; nonzero location inputs must not move the origin.
        run_op("clear", 2'b10, 0, 7, 9, 76800, 76801, 1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/sprite_draw_engine.md
SPRITE_DRAW_ENGINE -- requirements
Module: sprite_draw_engine

Interface
REQ-001 SHALL have parameter N_SPR, default 4, number of sprite images held in sprite ROM.
REQ-002 SHALL have parameter SPR_W, default 16, sprite width in pixels.
REQ-003 SHALL have parameter SPR_H, default 16, sprite height in pixels.
REQ-004 SHALL have parameter COLOUR_W, default 15, pixel colour width.
REQ-005 SHALL have parameter BG_COLOUR, default 0, colour written by erase/clear.
REQ-006 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-007 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-008 SHALL have port start  input  1  one-cycle command request.
REQ-009 SHALL have port mode  input  2  00 draw sprite, 01 erase rectangle, 10 clear screen, 11 reserved.
REQ-010 SHALL have port spr_id  input  $clog2(N_SPR)  sprite index for draw.
REQ-011 SHALL have port loc_x  input  9  top-left X; loc_y  input  8  top-left Y.
REQ-012 SHALL have port rom_addr  output  $clog2(N_SPR*SPR_W*SPR_H)  sprite ROM address.
REQ-013 SHALL have port rom_data  input  COLOUR_W  ROM read data, valid one cycle after rom_addr.
REQ-014 SHALL have ports X  output  9, Y  output  8, colour  output  COLOUR_W, plot  output  1  pixel write to VGA adapter.
REQ-015 SHALL have ports busy  output  1 and done  output  1 (one-cycle completion pulse).

Function
REQ-016 SHALL implement states IDLE, SCAN, FLUSH, DONE.
REQ-017 SHALL accept start only in IDLE; start while busy=1 SHALL be ignored.
REQ-018 SHALL latch mode, spr_id, loc_x, loc_y on accepted start; later input changes SHALL not affect the operation.
REQ-019 start with mode 11 SHALL be ignored: no state change, no busy, no done.
REQ-020 Draw/erase SHALL scan cx 0..SPR_W-1 (inner), cy 0..SPR_H-1 (outer), one pixel per cycle, row-major.
REQ-021 Clear SHALL scan cx 0..319, cy 0..239 with origin (0,0).
REQ-022 In draw, rom_addr SHALL equal spr_id*SPR_W*SPR_H + cy*SPR_W + cx in the scan cycle.
REQ-023 Pixel outputs SHALL lag the scan by exactly one cycle: X=loc_x+cx, Y=loc_y+cy, colour=rom_data (draw) or BG_COLOUR (erase/clear).
REQ-024 X/Y sums SHALL be computed one bit wider; pixels with X>=320 or Y>=240 SHALL have plot=0 (clipped, no wrap).
REQ-025 SCAN SHALL enter FLUSH after the last pixel address; FLUSH emits the final pixel, then DONE.
REQ-026 DONE SHALL assert done=1 for one cycle, busy=0, return to IDLE; start in DONE cycle SHALL be ignored.
REQ-027 busy SHALL be 1 from the cycle after acceptance through FLUSH: SPR_W*SPR_H+1 cycles (draw/erase), 76801 (clear).
REQ-028 plot SHALL be 0 in IDLE and DONE.

Reset
REQ-029 reset=0 SHALL asynchronously force IDLE, counters 0, rom_addr=0, X=0, Y=0, colour=0, plot=0, busy=0, done=0.
REQ-030 reset asserted mid-operation SHALL abort without done; no pixel SHALL be plotted after reset release until a new start.

Configuration
REQ-031 Macro SPRITE_TRANSPARENCY_EN defined: draw pixels whose rom_data equals all-ones SHALL have plot=0; erase/clear unaffected.
REQ-032 Macro SPRITE_TRANSPARENCY_EN undefined: every in-screen draw pixel SHALL be plotted regardless of value.

Structure
REQ-033 Package sprite_draw_pkg SHALL hold mode encodings, state enum, SCREEN_W=320, SCREEN_H=240, transparent key.
REQ-034 Sub-module sprite_scan_counter SHALL implement the parametrised 2-D cx/cy counter with last-pixel flag.

Verification
REQ-035 Draw id=2 at (10,20), SPR 16x16 -> rom_addr 512..767, 256 plots X 10..25 Y 20..35, done at cycle 258 after start.
REQ-036 Draw at (310,230) -> only 10x10=100 pixels plotted; no X>=320 or Y>=240 with plot=1.
REQ-037 Clear -> 76800 plots, colour=BG_COLOUR, busy 76801 cycles, single done pulse.
REQ-038 start with mode 11, and start pulsed during active draw -> neither affects outputs or busy.
REQ-039 reset low at pixel 100 of draw -> all outputs 0 same cycle, no done, IDLE after release.
REQ-040 With SPRITE_TRANSPARENCY_EN, ROM row of 16'h7FFF pixels -> that row's plot=0; without macro -> plotted.
